// File: rtl/pred_upd_sched.sv
// Predictor table port scheduler: post-reset clear sweep, then lookup/update arbitration.
// Optional statistics counters are enabled with the PRED_UPD_STATS_EN macro.
module pred_upd_sched #(
    parameter int PHT_WIDTH    = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 if_req_en,
    input  logic [31:0]          if_req_pc,
    output logic                 if_grant,
    input  logic                 rob_upd_en,
    input  logic [31:0]          rob_upd_pc,
    input  logic                 rob_upd_taken,
    output logic                 rob_upd_ready,
    output logic                 pred_lookup_en,
    output logic [31:0]          pred_lookup_pc,
    output logic                 pred_upd_en,
    output logic [31:0]          pred_upd_pc,
    output logic                 pred_upd_taken,
    output logic                 pred_clr_en,
    output logic [PHT_WIDTH-1:0] pred_clr_idx,
    output logic                 init_done,
    output logic [31:0]          stat_upd_cnt,
    output logic [31:0]          stat_forced_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_FULL  = CW'(FIFO_DEPTH);
    localparam logic [3:0]    L_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [PHT_WIDTH-1:0]  r_clr_idx;
    logic [31:0]           r_mem_pc [FIFO_DEPTH];
    logic                  r_mem_tk [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [3:0]            r_wait;
    logic [31:0]           r_last_pc;
    logic                  r_last_tk;

    logic w_act, w_empty, w_full, w_force;
    logic w_clr, w_grant, w_pop, w_push, w_ready;

    always_comb begin
        w_act      = rdy_in && !rst_in;
        w_empty    = (r_count == '0);
        w_full     = (r_count == L_FULL);
        w_force    = w_full || (!w_empty && (r_wait >= L_LIMIT));
        w_state_nx = r_state;
        w_clr      = 1'b0;
        w_grant    = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_act) begin
                    w_clr = 1'b1;
                    if (&r_clr_idx)
                        w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                // Lookups win unless the head update has waited too long
                if (w_act) begin
                    if (w_empty)
                        w_grant = if_req_en;
                    else if (!if_req_en)
                        w_pop = 1'b1;
                    else if (!w_force)
                        w_grant = 1'b1;
                    else
                        w_pop = 1'b1;
                end
            end
            default: w_state_nx = ST_INIT;
        endcase
        w_ready = w_act && !w_full;
        w_push  = rob_upd_en && w_ready;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in)
            r_state <= ST_INIT;
        else if (rdy_in)
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_clr_idx <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wait    <= '0;
            r_last_pc <= '0;
            r_last_tk <= 1'b0;
        end else if (rdy_in) begin
            if (w_clr)
                r_clr_idx <= r_clr_idx + PHT_WIDTH'(1);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop)
                r_wait <= '0;
            else if (w_grant && !w_empty && (r_wait != 4'hF))
                r_wait <= r_wait + 4'd1;
            // Shadow of the head so the outputs hold after the FIFO drains
            if (!w_empty) begin
                r_last_pc <= r_mem_pc[r_rd_ptr];
                r_last_tk <= r_mem_tk[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr] <= rob_upd_pc;
            r_mem_tk[r_wr_ptr] <= rob_upd_taken;
        end
    end

    assign if_grant       = w_grant;
    assign pred_lookup_en = w_grant;
    assign pred_lookup_pc = if_req_pc;
    assign pred_upd_en    = w_pop;
    assign pred_upd_pc    = w_empty ? r_last_pc : r_mem_pc[r_rd_ptr];
    assign pred_upd_taken = w_empty ? r_last_tk : r_mem_tk[r_rd_ptr];
    assign pred_clr_en    = w_clr;
    assign pred_clr_idx   = r_clr_idx;
    assign init_done      = (r_state == ST_RUN);
    assign rob_upd_ready  = w_ready;

`ifdef PRED_UPD_STATS_EN
    logic [31:0] r_stat_upd;
    logic [31:0] r_stat_forced;

    // A pop while fetch is requesting can only be a forced pop
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_stat_upd    <= '0;
            r_stat_forced <= '0;
        end else begin
            if (w_pop)
                r_stat_upd <= r_stat_upd + 32'd1;
            if (w_pop && if_req_en)
                r_stat_forced <= r_stat_forced + 32'd1;
        end
    end

    assign stat_upd_cnt    = r_stat_upd;
    assign stat_forced_cnt = r_stat_forced;
`else
    assign stat_upd_cnt    = '0;
    assign stat_forced_cnt = '0;
`endif

endmodule

// File: tb/tb_pred_upd_sched.sv
// Directed testbench for pred_upd_sched (default parameters).
// Statistics expectations follow PRED_UPD_STATS_EN.
module tb_pred_upd_sched;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req_en;
    logic [31:0] if_req_pc;
    logic        if_grant;
    logic        rob_upd_en;
    logic [31:0] rob_upd_pc;
    logic        rob_upd_taken;
    logic        rob_upd_ready;
    logic        pred_lookup_en;
    logic [31:0] pred_lookup_pc;
    logic        pred_upd_en;
    logic [31:0] pred_upd_pc;
    logic        pred_upd_taken;
    logic        pred_clr_en;
    logic [5:0]  pred_clr_idx;
    logic        init_done;
    logic [31:0] stat_upd_cnt;
    logic [31:0] stat_forced_cnt;

    int checks = 0;
    int errors = 0;

`ifdef PRED_UPD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    pred_upd_sched dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .if_req_en      (if_req_en),
        .if_req_pc      (if_req_pc),
        .if_grant       (if_grant),
        .rob_upd_en     (rob_upd_en),
        .rob_upd_pc     (rob_upd_pc),
        .rob_upd_taken  (rob_upd_taken),
        .rob_upd_ready  (rob_upd_ready),
        .pred_lookup_en (pred_lookup_en),
        .pred_lookup_pc (pred_lookup_pc),
        .pred_upd_en    (pred_upd_en),
        .pred_upd_pc    (pred_upd_pc),
        .pred_upd_taken (pred_upd_taken),
        .pred_clr_en    (pred_clr_en),
        .pred_clr_idx   (pred_clr_idx),
        .init_done      (init_done),
        .stat_upd_cnt   (stat_upd_cnt),
        .stat_forced_cnt(stat_forced_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step();
        step();
        checks++;
        if ({pred_clr_en, init_done, if_grant, pred_upd_en, rob_upd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_en clr=%b done=%b gnt=%b upd=%b rdy=%b want all 0",
                     pred_clr_en, init_done, if_grant, pred_upd_en, rob_upd_ready);
        end
        checks++;
        if (stat_upd_cnt !== 32'd0 || stat_forced_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats upd=%0d forced=%0d want 0 0",
                     stat_upd_cnt, stat_forced_cnt);
        end
        rst_in = 1'b0;
        #1;
    endtask

    task automatic test_init_sweep;
        if_req_en = 1'b1;
        if_req_pc = 32'h200;
        #1;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (pred_clr_en !== 1'b1 || pred_clr_idx !== 6'(i) ||
                if_grant !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL sweep_%0d clr=%b idx=%0d gnt=%b done=%b want 1 %0d 0 0",
                         i, pred_clr_en, pred_clr_idx, if_grant, init_done, i);
            end
            step();
        end
        checks++;
        if (init_done !== 1'b1 || pred_clr_en !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end done=%b clr=%b want 1 0", init_done, pred_clr_en);
        end
    endtask

    task automatic test_lookup;
        if_req_pc = 32'h100;
        #1;
        checks++;
        if (if_grant !== 1'b1 || pred_lookup_en !== 1'b1 ||
            pred_lookup_pc !== 32'h100) begin
            errors++;
            $display("FAIL lookup gnt=%b en=%b pc=%h want 1 1 00000100",
                     if_grant, pred_lookup_en, pred_lookup_pc);
        end
    endtask

    task automatic test_starve;
        rob_upd_en    = 1'b1;
        rob_upd_pc    = 32'h40;
        rob_upd_taken = 1'b1;
        #1;
        checks++;
        if (rob_upd_ready !== 1'b1 || if_grant !== 1'b1) begin
            errors++;
            $display("FAIL starve_push rdy=%b gnt=%b want 1 1", rob_upd_ready, if_grant);
        end
        step();
        rob_upd_en = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (if_grant !== 1'b1 || pred_upd_en !== 1'b0 || pred_upd_pc !== 32'h40) begin
                errors++;
                $display("FAIL starve_wait%0d gnt=%b upd=%b pc=%h want 1 0 00000040",
                         k, if_grant, pred_upd_en, pred_upd_pc);
            end
            step();
        end
        checks++;
        if (pred_upd_en !== 1'b1 || if_grant !== 1'b0 ||
            pred_upd_pc !== 32'h40 || pred_upd_taken !== 1'b1) begin
            errors++;
            $display("FAIL starve_force upd=%b gnt=%b pc=%h tk=%b want 1 0 00000040 1",
                     pred_upd_en, if_grant, pred_upd_pc, pred_upd_taken);
        end
        step();
        checks++;
        if (if_grant !== 1'b1 || pred_upd_en !== 1'b0 ||
            pred_upd_pc !== 32'h40 || pred_upd_taken !== 1'b1) begin
            errors++;
            $display("FAIL starve_after gnt=%b upd=%b pc=%h tk=%b want 1 0 00000040 1",
                     if_grant, pred_upd_en, pred_upd_pc, pred_upd_taken);
        end
        checks++;
        if (stat_upd_cnt !== (STATS ? 32'd1 : 32'd0) ||
            stat_forced_cnt !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL starve_stats upd=%0d forced=%0d want %0d %0d",
                     stat_upd_cnt, stat_forced_cnt, STATS, STATS);
        end
    endtask

    task automatic test_full;
        logic [31:0] pcs [4];
        pcs = '{32'h10, 32'h20, 32'h30, 32'h40};
        if_req_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rob_upd_en    = 1'b1;
            rob_upd_pc    = pcs[i];
            rob_upd_taken = i[0];
            #1;
            checks++;
            if (rob_upd_ready !== 1'b1 || if_grant !== 1'b1) begin
                errors++;
                $display("FAIL full_push%0d rdy=%b gnt=%b want 1 1",
                         i, rob_upd_ready, if_grant);
            end
            step();
        end
        rob_upd_en    = 1'b1;
        rob_upd_pc    = 32'hDEAD;
        rob_upd_taken = 1'b0;
        #1;
        checks++;
        if (rob_upd_ready !== 1'b0 || pred_upd_en !== 1'b1 || if_grant !== 1'b0 ||
            pred_upd_pc !== 32'h10 || pred_upd_taken !== 1'b0) begin
            errors++;
            $display("FAIL full_force rdy=%b upd=%b gnt=%b pc=%h tk=%b want 0 1 0 00000010 0",
                     rob_upd_ready, pred_upd_en, if_grant, pred_upd_pc, pred_upd_taken);
        end
        step();
        rob_upd_en = 1'b0;
        if_req_en  = 1'b0;
        #1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (pred_upd_en !== 1'b1 || pred_upd_pc !== pcs[i] ||
                pred_upd_taken !== i[0]) begin
                errors++;
                $display("FAIL full_pop%0d upd=%b pc=%h tk=%b want 1 %h %b",
                         i, pred_upd_en, pred_upd_pc, pred_upd_taken, pcs[i], i[0]);
            end
            step();
        end
        checks++;
        if (pred_upd_en !== 1'b0 || if_grant !== 1'b0) begin
            errors++;
            $display("FAIL full_empty upd=%b gnt=%b want 0 0", pred_upd_en, if_grant);
        end
        checks++;
        if (stat_upd_cnt !== (STATS ? 32'd5 : 32'd0) ||
            stat_forced_cnt !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL full_stats upd=%0d forced=%0d want %0d %0d",
                     stat_upd_cnt, stat_forced_cnt, STATS ? 5 : 0, STATS ? 2 : 0);
        end
    endtask

    task automatic test_push_pop;
        if_req_en     = 1'b1;
        rob_upd_en    = 1'b1;
        rob_upd_pc    = 32'h50;
        rob_upd_taken = 1'b1;
        #1;
        step();
        rob_upd_pc    = 32'h60;
        rob_upd_taken = 1'b0;
        #1;
        step();
        if_req_en     = 1'b0;
        rob_upd_pc    = 32'h70;
        rob_upd_taken = 1'b1;
        #1;
        checks++;
        if (rob_upd_ready !== 1'b1 || pred_upd_en !== 1'b1 ||
            pred_upd_pc !== 32'h50 || pred_upd_taken !== 1'b1) begin
            errors++;
            $display("FAIL pp_both rdy=%b upd=%b pc=%h tk=%b want 1 1 00000050 1",
                     rob_upd_ready, pred_upd_en, pred_upd_pc, pred_upd_taken);
        end
        step();
        rob_upd_en = 1'b0;
        #1;
        checks++;
        if (pred_upd_en !== 1'b1 || pred_upd_pc !== 32'h60 || pred_upd_taken !== 1'b0) begin
            errors++;
            $display("FAIL pp_pop2 upd=%b pc=%h tk=%b want 1 00000060 0",
                     pred_upd_en, pred_upd_pc, pred_upd_taken);
        end
        step();
        checks++;
        if (pred_upd_en !== 1'b1 || pred_upd_pc !== 32'h70 || pred_upd_taken !== 1'b1) begin
            errors++;
            $display("FAIL pp_pop3 upd=%b pc=%h tk=%b want 1 00000070 1",
                     pred_upd_en, pred_upd_pc, pred_upd_taken);
        end
        step();
        checks++;
        if (pred_upd_en !== 1'b0) begin
            errors++;
            $display("FAIL pp_empty upd=%b want 0", pred_upd_en);
        end
        checks++;
        if (stat_upd_cnt !== (STATS ? 32'd8 : 32'd0)) begin
            errors++;
            $display("FAIL pp_stats upd=%0d want %0d", stat_upd_cnt, STATS ? 8 : 0);
        end
    endtask

    task automatic test_reset_mid_run;
        if_req_en     = 1'b1;
        rob_upd_en    = 1'b1;
        rob_upd_pc    = 32'h80;
        rob_upd_taken = 1'b1;
        #1;
        step();
        rob_upd_en = 1'b0;
        rst_in     = 1'b1;
        #1;
        checks++;
        if (init_done !== 1'b0 || pred_clr_en !== 1'b0 ||
            pred_upd_en !== 1'b0 || rob_upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_run done=%b clr=%b upd=%b rdy=%b want 0 0 0 0",
                     init_done, pred_clr_en, pred_upd_en, rob_upd_ready);
        end
        step();
        rst_in = 1'b0;
        #1;
        checks++;
        if (pred_clr_en !== 1'b1 || pred_clr_idx !== 6'd0 || if_grant !== 1'b0) begin
            errors++;
            $display("FAIL rst_reinit clr=%b idx=%0d gnt=%b want 1 0 0",
                     pred_clr_en, pred_clr_idx, if_grant);
        end
    endtask

    task automatic test_rdy_init;
        if_req_en = 1'b0;
        for (int i = 0; i < 10; i++)
            step();
        checks++;
        if (pred_clr_en !== 1'b1 || pred_clr_idx !== 6'd10) begin
            errors++;
            $display("FAIL rdy_at10 clr=%b idx=%0d want 1 10", pred_clr_en, pred_clr_idx);
        end
        rdy_in = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (pred_clr_en !== 1'b0 || pred_clr_idx !== 6'd10 ||
                rob_upd_ready !== 1'b0) begin
                errors++;
                $display("FAIL rdy_hold%0d clr=%b idx=%0d rdy=%b want 0 10 0",
                         j, pred_clr_en, pred_clr_idx, rob_upd_ready);
            end
            step();
        end
        rdy_in = 1'b1;
        #1;
        checks++;
        if (pred_clr_en !== 1'b1 || pred_clr_idx !== 6'd10) begin
            errors++;
            $display("FAIL rdy_resume clr=%b idx=%0d want 1 10", pred_clr_en, pred_clr_idx);
        end
        for (int i = 0; i < 54; i++)
            step();
        checks++;
        if (init_done !== 1'b1 || pred_upd_en !== 1'b0 || rob_upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rdy_run done=%b upd=%b rdy=%b want 1 0 1",
                     init_done, pred_upd_en, rob_upd_ready);
        end
        checks++;
        if (stat_upd_cnt !== 32'd0 || stat_forced_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rdy_stats upd=%0d forced=%0d want 0 0",
                     stat_upd_cnt, stat_forced_cnt);
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        if_req_en     = 1'b0;
        if_req_pc     = '0;
        rob_upd_en    = 1'b0;
        rob_upd_pc    = '0;
        rob_upd_taken = 1'b0;
        test_reset();
        test_init_sweep();
        test_lookup();
        test_starve();
        test_full();
        test_push_pop();
        test_reset_mid_run();
        test_rdy_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
